// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for MulCPU: state register, next-state decode, done/illegal pulses.
// Optional performance counters (cycle_cnt, instr_cnt) are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl_fsm #(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] OP_ADD  = 6'b000000,
    parameter logic [OP_W-1:0] OP_SUB  = 6'b000001,
    parameter logic [OP_W-1:0] OP_ADDI = 6'b000010,
    parameter logic [OP_W-1:0] OP_OR   = 6'b010000,
    parameter logic [OP_W-1:0] OP_AND  = 6'b010001,
    parameter logic [OP_W-1:0] OP_ORI  = 6'b010010,
    parameter logic [OP_W-1:0] OP_SLL  = 6'b011000,
    parameter logic [OP_W-1:0] OP_MOVE = 6'b100000,
    parameter logic [OP_W-1:0] OP_SLT  = 6'b100111,
    parameter logic [OP_W-1:0] OP_SW   = 6'b110000,
    parameter logic [OP_W-1:0] OP_LW   = 6'b110001,
    parameter logic [OP_W-1:0] OP_BEQ  = 6'b110100,
    parameter logic [OP_W-1:0] OP_J    = 6'b111000,
    parameter logic [OP_W-1:0] OP_JR   = 6'b111001,
    parameter logic [OP_W-1:0] OP_JAL  = 6'b111010,
    parameter logic [OP_W-1:0] OP_HALT = 6'b111111
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            run_en,
    input  logic            mem_ready,
    input  logic            resume,
    output logic [3:0]      state,
    output logic [3:0]      next_state,
    output logic            instr_done,
    output logic            halted,
    output logic            illegal_op
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IF      = 4'b0000,
        S_ID      = 4'b0001,
        S_MEM_ADR = 4'b0010,
        S_MEM_ACC = 4'b0011,
        S_WB_LD   = 4'b0100,
        S_EXE_BR  = 4'b0101,
        S_EXE_ALU = 4'b0110,
        S_WB_ALU  = 4'b0111,
        S_HALT    = 4'b1000
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_MEM, C_BR, C_JMP, C_HALT, C_BAD
    } op_class_t;

    state_t    state_q;
    state_t    state_d;
    op_class_t op_class;
    logic      done_d;
    logic      illegal_d;

    always_comb begin
        op_class = C_BAD;
        case (opcode)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
            OP_ORI, OP_SLL, OP_MOVE, OP_SLT:        op_class = C_ALU;
            OP_SW, OP_LW:                           op_class = C_MEM;
            OP_BEQ:                                 op_class = C_BR;
            OP_J, OP_JR, OP_JAL:                    op_class = C_JMP;
            OP_HALT:                                op_class = C_HALT;
            default:                                op_class = C_BAD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (Reset) begin
            state_d = S_IF;
        end else begin
            case (state_q)
                S_IF:      state_d = (run_en && mem_ready) ? S_ID : S_IF;
                S_ID: begin
                    case (op_class)
                        C_ALU:   state_d = S_EXE_ALU;
                        C_MEM:   state_d = S_MEM_ADR;
                        C_BR:    state_d = S_EXE_BR;
                        C_HALT:  state_d = S_HALT;
                        default: state_d = S_IF;
                    endcase
                end
                S_MEM_ADR: state_d = S_MEM_ACC;
                S_MEM_ACC: begin
                    if (mem_ready)
                        state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
                end
                S_WB_LD:   state_d = S_IF;
                S_EXE_BR:  state_d = S_IF;
                S_EXE_ALU: state_d = S_WB_ALU;
                S_WB_ALU:  state_d = S_IF;
                S_HALT:    state_d = resume ? S_IF : S_HALT;
                default:   state_d = S_IF;
            endcase
        end
    end

    // Leaving HALT is a restart, not a completed instruction, so it does not count as done.
    always_comb begin
        done_d    = (state_d == S_IF) && (state_q != S_IF) && (state_q != S_HALT);
        illegal_d = (state_q == S_ID) && (op_class == C_BAD);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= S_IF;
            instr_done <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_done <= done_d;
            illegal_op <= illegal_d;
        end
    end

    assign state      = state_q;
    assign next_state = state_d;
    assign halted     = (state_q == S_HALT);

`ifdef MC_CTRL_PERF_EN
    // instr_cnt steps on the same edge that raises instr_done, so both read as current together.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (state_q != S_HALT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (done_d)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed steps push expected post-edge outputs, a monitor checks them.
module tb_mc_ctrl_fsm;

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] ORI  = 6'b010010;
    localparam logic [5:0] SLT  = 6'b100111;
    localparam logic [5:0] SW   = 6'b110000;
    localparam logic [5:0] LW   = 6'b110001;
    localparam logic [5:0] BEQ  = 6'b110100;
    localparam logic [5:0] J    = 6'b111000;
    localparam logic [5:0] JR   = 6'b111001;
    localparam logic [5:0] JAL  = 6'b111010;
    localparam logic [5:0] HLT  = 6'b111111;
    localparam logic [5:0] BAD  = 6'b101010;

    localparam logic [3:0] IF = 4'd0, ID = 4'd1, MA = 4'd2, MC = 4'd3, WL = 4'd4;
    localparam logic [3:0] EB = 4'd5, EA = 4'd6, WA = 4'd7, HT = 4'd8;

    typedef struct {
        logic [3:0]  st;
        logic        done;
        logic        ill;
        logic        chk_perf;
        logic [31:0] cyc;
        logic [31:0] icnt;
    } exp_t;

    logic        CLK;
    logic        Reset;
    logic [5:0]  opcode;
    logic        run_en;
    logic        mem_ready;
    logic        resume;
    logic [3:0]  state;
    logic [3:0]  next_state;
    logic        instr_done;
    logic        halted;
    logic        illegal_op;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;
    logic        perf_chk = 1'b0;
    logic [31:0] perf_cyc = 32'd0;
    logic [31:0] perf_icnt = 32'd0;

    mc_ctrl_fsm dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .opcode     (opcode),
        .run_en     (run_en),
        .mem_ready  (mem_ready),
        .resume     (resume),
        .state      (state),
        .next_state (next_state),
        .instr_done (instr_done),
        .halted     (halted),
        .illegal_op (illegal_op)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_no, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show after the next rising edge.
    task automatic apply_stimulus(input logic r, input logic run, input logic mr, input logic [5:0] op,
                                  input logic res, input logic [3:0] st, input logic done, input logic ill);
        exp_t e;
        Reset     = r;
        run_en    = run;
        mem_ready = mr;
        opcode    = op;
        resume    = res;
        e.st       = st;
        e.done     = done;
        e.ill      = ill;
        e.chk_perf = perf_chk;
        e.cyc      = perf_cyc;
        e.icnt     = perf_icnt;
        perf_chk   = 1'b0;
        sb.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc_no++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("state", {28'd0, state}, {28'd0, e.st});
                check_output("instr_done", {31'd0, instr_done}, {31'd0, e.done});
                check_output("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
                check_output("halted", {31'd0, halted}, {31'd0, (e.st == HT)});
`ifdef MC_CTRL_PERF_EN
                if (e.chk_perf) begin
                    check_output("cycle_cnt", cycle_cnt, e.cyc);
                    check_output("instr_cnt", instr_cnt, e.icnt);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        Reset = 1'b1; run_en = 1'b0; mem_ready = 1'b1; opcode = ADD; resume = 1'b0;
        @(posedge CLK);
        #2;

        // Reset has priority even with run_en asserted; counters read zero.
        perf_chk = 1'b1; perf_cyc = 32'd0; perf_icnt = 32'd0;
        apply_stimulus(1, 0, 1, ADD, 0, IF, 0, 0);
        apply_stimulus(1, 1, 1, ADD, 0, IF, 0, 0);

        // ADD, BEQ, J back to back: 4 + 3 + 2 cycles, third done at cycle 9.
        apply_stimulus(0, 1, 1, ADD, 0, ID, 0, 0);
        apply_stimulus(0, 1, 1, ADD, 0, EA, 0, 0);
        apply_stimulus(0, 1, 1, ADD, 0, WA, 0, 0);
        apply_stimulus(0, 1, 1, ADD, 0, IF, 1, 0);
        apply_stimulus(0, 1, 1, BEQ, 0, ID, 0, 0);
        apply_stimulus(0, 1, 1, BEQ, 0, EB, 0, 0);
        apply_stimulus(0, 1, 1, BEQ, 0, IF, 1, 0);
        apply_stimulus(0, 1, 1, J,   0, ID, 0, 0);
        perf_chk = 1'b1; perf_cyc = 32'd9; perf_icnt = 32'd3;
        apply_stimulus(0, 1, 1, J,   0, IF, 1, 0);
        apply_stimulus(0, 0, 1, J,   0, IF, 0, 0);

        // IF holds while memory is not ready.
        apply_stimulus(0, 1, 0, LW, 0, IF, 0, 0);

        // LW with three wait cycles in MEM_ACC.
        apply_stimulus(0, 1, 1, LW, 0, ID, 0, 0);
        apply_stimulus(0, 1, 0, LW, 0, MA, 0, 0);
        apply_stimulus(0, 1, 0, LW, 0, MC, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, LW, 0, MC, 0, 0);
        apply_stimulus(0, 1, 1, LW, 0, WL, 0, 0);
        apply_stimulus(0, 0, 1, LW, 0, IF, 1, 0);
        apply_stimulus(0, 0, 1, LW, 0, IF, 0, 0);

        // SW skips the load writeback.
        apply_stimulus(0, 1, 1, SW, 0, ID, 0, 0);
        apply_stimulus(0, 1, 1, SW, 0, MA, 0, 0);
        apply_stimulus(0, 1, 1, SW, 0, MC, 0, 0);
        apply_stimulus(0, 1, 1, SW, 0, IF, 1, 0);
        apply_stimulus(0, 0, 1, SW, 0, IF, 0, 0);

        // Other ALU and jump encodings.
        apply_stimulus(0, 1, 1, SLT, 0, ID, 0, 0);
        apply_stimulus(0, 1, 1, SLT, 0, EA, 0, 0);
        apply_stimulus(0, 1, 1, SLT, 0, WA, 0, 0);
        apply_stimulus(0, 1, 1, SLT, 0, IF, 1, 0);
        apply_stimulus(0, 1, 1, ORI, 0, ID, 0, 0);
        apply_stimulus(0, 1, 1, ORI, 0, EA, 0, 0);
        apply_stimulus(0, 1, 1, ORI, 0, WA, 0, 0);
        apply_stimulus(0, 1, 1, ORI, 0, IF, 1, 0);
        apply_stimulus(0, 1, 1, JR,  0, ID, 0, 0);
        apply_stimulus(0, 1, 1, JR,  0, IF, 1, 0);
        apply_stimulus(0, 1, 1, JAL, 0, ID, 0, 0);
        apply_stimulus(0, 0, 1, JAL, 0, IF, 1, 0);
        apply_stimulus(0, 0, 1, JAL, 0, IF, 0, 0);

        // HALT holds ten cycles with no done, resume returns to IF without a done pulse.
        apply_stimulus(0, 1, 1, HLT, 0, ID, 0, 0);
        apply_stimulus(0, 1, 1, HLT, 0, HT, 0, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 1, HLT, 0, HT, 0, 0);
        apply_stimulus(0, 1, 1, HLT, 1, IF, 0, 0);
        apply_stimulus(0, 0, 1, HLT, 0, IF, 0, 0);

        // resume outside HALT is ignored.
        apply_stimulus(0, 0, 1, ADD, 1, IF, 0, 0);
        apply_stimulus(0, 1, 1, ADD, 1, ID, 0, 0);
        apply_stimulus(0, 1, 1, ADD, 1, EA, 0, 0);
        apply_stimulus(0, 1, 1, ADD, 0, WA, 0, 0);
        apply_stimulus(0, 0, 1, ADD, 0, IF, 1, 0);

        // Undefined opcode returns straight to IF with a one-cycle illegal flag.
        apply_stimulus(0, 1, 1, BAD, 0, ID, 0, 0);
        apply_stimulus(0, 0, 1, BAD, 0, IF, 1, 1);
        apply_stimulus(0, 0, 1, BAD, 0, IF, 0, 0);

        // Reset while stalled in MEM_ACC; IF then holds with run_en low.
        apply_stimulus(0, 1, 1, LW, 0, ID, 0, 0);
        apply_stimulus(0, 1, 0, LW, 0, MA, 0, 0);
        apply_stimulus(0, 1, 0, LW, 0, MC, 0, 0);
        perf_chk = 1'b1; perf_cyc = 32'd0; perf_icnt = 32'd0;
        apply_stimulus(1, 1, 0, LW, 0, IF, 0, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, LW, 0, IF, 0, 0);

        // Reset out of HALT and out of an illegal ID cycle.
        apply_stimulus(0, 1, 1, HLT, 0, ID, 0, 0);
        apply_stimulus(0, 1, 1, HLT, 0, HT, 0, 0);
        apply_stimulus(1, 1, 1, HLT, 0, IF, 0, 0);
        apply_stimulus(0, 1, 1, BAD, 0, ID, 0, 0);
        apply_stimulus(1, 1, 1, BAD, 0, IF, 0, 0);
        apply_stimulus(0, 0, 1, BAD, 0, IF, 0, 0);

        repeat (2) @(posedge CLK);
        #3;
        check_output("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Registered multicycle control sequencer for the MulCPU datapath. Owns the state register and next-state logic.
- Adds memory-wait stalls, a halt state with resume, run gating at instruction boundaries, and an illegal-opcode flag.
- Sits between the instruction register (opcode field) and the control-signal decoder, which consumes `state`.

Parameters:
- OP_W, 6, opcode field width.
- OP_ADD, 6'b000000; OP_SUB, 6'b000001; OP_ADDI, 6'b000010; OP_OR, 6'b010000; OP_AND, 6'b010001; OP_ORI, 6'b010010; OP_SLL, 6'b011000; OP_MOVE, 6'b100000; OP_SLT, 6'b100111: ALU class.
- OP_SW, 6'b110000; OP_LW, 6'b110001: memory class.
- OP_BEQ, 6'b110100: branch class.
- OP_J, 6'b111000; OP_JR, 6'b111001; OP_JAL, 6'b111010: jump class.
- OP_HALT, 6'b111111: halt.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- opcode  in  OP_W  IR opcode field; valid from ID onward.
- run_en  in  1  permits leaving IF.
- mem_ready  in  1  memory access complete; tie 1 for zero-wait memory.
- resume  in  1  single-cycle pulse that exits HALT.
- state  out  4  current state.
- next_state  out  4  combinational next state.
- instr_done  out  1  registered pulse, 1 cycle.
- halted  out  1  high while in HALT.
- illegal_op  out  1  registered pulse, 1 cycle.

Behaviour:
- State encoding: IF=0000, ID=0001, MEM_ADDR=0010, MEM_ACC=0011, WB_LD=0100, EXE_BR=0101, EXE_ALU=0110, WB_ALU=0111, HALT=1000. Codes 1001-1111 are unused.
- Reset values: state=IF, instr_done=0, illegal_op=0, halted=0. Reset has priority over all other inputs in any state, including mid-instruction and HALT.
- IF: stay in IF while run_en=0 or mem_ready=0; otherwise go to ID.
- ID, decoded from opcode:
  - ALU class -> EXE_ALU.
  - BEQ -> EXE_BR.
  - SW or LW -> MEM_ADDR.
  - J/JR/JAL -> IF.
  - HALT -> HALT.
  - Any other code -> IF, and pulse illegal_op on the next cycle.
- EXE_ALU->WB_ALU; WB_ALU->IF; EXE_BR->IF; MEM_ADDR->MEM_ACC; WB_LD->IF.
- MEM_ACC: stay while mem_ready=0. When mem_ready=1: LW -> WB_LD, SW -> IF.
- HALT: stay until resume=1, then -> IF. resume in any other state is ignored.
- Unused codes -> IF on the next edge; illegal_op is not pulsed.
- instr_done: asserted in the cycle after any transition into IF from a non-IF state. Not asserted for the Reset entry, nor for the HALT->IF transition.
- halted = (state==HALT), combinational from the state register.
- next_state is the pure combinational function of (state, opcode, run_en, mem_ready, resume, Reset). Reset forces it to IF.
- Cycles per instruction with mem_ready=1: ALU 4, BEQ 3, J-class 2, SW 4, LW 5.
- opcode is sampled every cycle from ID onward; the IR must hold it stable until return to IF.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- When defined, add two outputs:
  - cycle_cnt [31:0]: increments every cycle while state!=HALT.
  - instr_cnt [31:0]: increments on each instr_done.
  - Both clear on Reset and wrap from 32'hFFFFFFFF to 0 silently. Same-cycle events each increment once.
- When undefined, neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset then run_en=1, mem_ready=1, opcode=OP_ADD. Required: state sequence 0000,0001,0110,0111,0000; instr_done pulses once, in the cycle after re-entering IF.
- opcode=OP_LW with mem_ready low for 3 cycles in MEM_ACC. Required: 0000,0001,0010,0011×4,0100,0000; total 8 cycles.
- opcode=OP_HALT. Required: state=1000 and halted=1, held for 10 cycles with no instr_done. Then a resume pulse gives state=0000 next cycle.
- opcode=6'b101010 (undefined). Required: ID->IF, illegal_op=1 for exactly one cycle, no stall.
- Reset asserted in MEM_ACC while mem_ready=0. Required: next state=0000, all outputs at reset values. With run_en=0, state remains 0000 indefinitely.
- With MC_CTRL_PERF_EN defined, run ADD,BEQ,J from reset. Required: instr_cnt=3 and cycle_cnt=9 at the third instr_done.
